// File: rtl/uart_io_arbiter.sv
// uart_io_arbiter: IO-port glue between a PicoBlaze-style processor bus and a
// single rs232_uart. Decodes the UART/status ports, queues processor TX bytes,
// and round-robin shares the UART TX/RX path with a debug loopback requester.
module uart_io_arbiter #(
    parameter int unsigned PQ_DEPTH  = 4,
    parameter int unsigned PQ_AW     = 2,
    parameter logic [7:0]  PORT_UART = 8'h01,
    parameter logic [7:0]  PORT_RXP  = 8'h02,
    parameter logic [7:0]  PORT_TXF  = 8'h03,
    parameter logic [7:0]  PORT_STAT = 8'h04
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] io_port_id,
    input  logic [7:0] io_write_data,
    input  logic       io_write_strobe,
    input  logic       io_read_strobe,
    output logic [7:0] io_read_data,
    input  logic       debug_req,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_present,
    output logic       uart_rx_ack,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_write,
    input  logic       uart_tx_full,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_PQ = 1'b0,
        REQ_LB = 1'b1
    } req_e;

    localparam logic [PQ_AW:0] PQ_FULL_CNT = (PQ_AW + 1)'(PQ_DEPTH);

    // Registered state
    logic [7:0]       rd_data_q;
    logic             rx_ack_q;
    logic             overflow_q;
    logic [1:0]       dbg_sync_q;
    logic             dbg_prev_q;
    logic             lb_pending_q;
    logic             lb_valid_q;
    logic [7:0]       lb_byte_q;
    logic [7:0]       pq_mem_q [PQ_DEPTH];
    logic [PQ_AW-1:0] pq_wr_ptr_q;
    logic [PQ_AW-1:0] pq_rd_ptr_q;
    logic [PQ_AW:0]   pq_count_q;
    state_e           state_q;
    req_e             grant_q;
    req_e             rr_last_q;
    logic [7:0]       tx_data_q;
    logic             tx_write_q;

    // Next-state / decode
    logic [7:0] rd_data_d;
    req_e       grant_d;
    logic [7:0] tx_byte_d;
    logic       proc_rd_uart;
    logic       rd_stat;
    logic       pq_push_req;
    logic       pq_push;
    logic       pq_pop;
    logic       pq_drop;
    logic       pq_full;
    logic       pq_empty;
    logic       lb_edge;
    logic       lb_pop;
    logic       lb_clr;
    logic [2:0] stat_cnt;
    logic [7:0] pq_head;

    assign proc_rd_uart = io_read_strobe  && (io_port_id == PORT_UART);
    assign rd_stat      = io_read_strobe  && (io_port_id == PORT_STAT);
    assign pq_push_req  = io_write_strobe && (io_port_id == PORT_UART);
    assign pq_full      = (pq_count_q == PQ_FULL_CNT);
    assign pq_empty     = (pq_count_q == '0);
    assign pq_pop       = (state_q == ST_ISSUE) && (grant_q == REQ_PQ);
    assign pq_push      = pq_push_req && (!pq_full || pq_pop);
    assign pq_drop      = pq_push_req && pq_full && !pq_pop;
    assign pq_head      = pq_mem_q[pq_rd_ptr_q];
    assign stat_cnt     = 3'(pq_count_q);
    assign lb_edge      = dbg_sync_q[1] && !dbg_prev_q;
    // The UART drops its FIFO head on the edge where rx_ack is high, so while an
    // ack is in flight the head still shows the byte being popped; the loopback
    // waits that cycle out to avoid capturing the same byte twice.
    assign lb_pop       = lb_pending_q && uart_rx_present && !proc_rd_uart && !rx_ack_q;
    assign lb_clr       = (state_q == ST_ISSUE) && (grant_q == REQ_LB);

    assign io_read_data  = rd_data_q;
    assign uart_rx_ack   = rx_ack_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_write = tx_write_q;
    assign overflow      = overflow_q;

    // Read port decode mux
    always_comb begin
        rd_data_d = '0;
        case (io_port_id)
            PORT_UART: rd_data_d = uart_rx_present ? uart_rx_data : '0;
            PORT_RXP:  rd_data_d = {7'b0, uart_rx_present};
            PORT_TXF:  rd_data_d = {7'b0, uart_tx_full | pq_full};
            PORT_STAT: rd_data_d = {overflow_q, lb_pending_q, lb_valid_q, 2'b00, stat_cnt};
            default:   rd_data_d = '0;
        endcase
    end

    // Registered read data, RX pop pulse and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rx_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (io_read_strobe) begin
                rd_data_q <= rd_data_d;
            end
            rx_ack_q <= (proc_rd_uart && uart_rx_present) || lb_pop;
            // A drop in the same cycle as a status read stays visible
            if (pq_drop) begin
                overflow_q <= 1'b1;
            end else if (rd_stat) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // debug_req synchronizer and edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_sync_q <= '0;
            dbg_prev_q <= 1'b0;
        end else begin
            dbg_sync_q <= {dbg_sync_q[0], debug_req};
            dbg_prev_q <= dbg_sync_q[1];
        end
    end

    // Loopback request / captured byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lb_pending_q <= 1'b0;
            lb_valid_q   <= 1'b0;
            lb_byte_q    <= '0;
        end else begin
            if (lb_edge && !lb_pending_q && !lb_valid_q) begin
                lb_pending_q <= 1'b1;
            end else if (lb_pop) begin
                lb_pending_q <= 1'b0;
            end
            if (lb_pop) begin
                lb_valid_q <= 1'b1;
                lb_byte_q  <= uart_rx_data;
            end else if (lb_clr) begin
                lb_valid_q <= 1'b0;
            end
        end
    end

    // Processor TX queue storage
    always_ff @(posedge clk) begin
        if (pq_push) begin
            pq_mem_q[pq_wr_ptr_q] <= io_write_data;
        end
    end

    // Processor TX queue pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pq_wr_ptr_q <= '0;
            pq_rd_ptr_q <= '0;
            pq_count_q  <= '0;
        end else begin
            if (pq_push) begin
                pq_wr_ptr_q <= pq_wr_ptr_q + PQ_AW'(1);
            end
            if (pq_pop) begin
                pq_rd_ptr_q <= pq_rd_ptr_q + PQ_AW'(1);
            end
            case ({pq_push, pq_pop})
                2'b10:   pq_count_q <= pq_count_q + (PQ_AW + 1)'(1);
                2'b01:   pq_count_q <= pq_count_q - (PQ_AW + 1)'(1);
                default: pq_count_q <= pq_count_q;
            endcase
        end
    end

    // Round-robin choice between queue head and loopback byte
    always_comb begin
        grant_d = REQ_PQ;
        if (!pq_empty && lb_valid_q) begin
            grant_d = (rr_last_q == REQ_PQ) ? REQ_LB : REQ_PQ;
        end else if (lb_valid_q) begin
            grant_d = REQ_LB;
        end
        tx_byte_d = (grant_d == REQ_LB) ? lb_byte_q : pq_head;
    end

    // TX arbiter FSM: IDLE grants, ISSUE pulses tx_write, GAP lets tx_full settle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= REQ_PQ;
            rr_last_q  <= REQ_PQ;
            tx_data_q  <= '0;
            tx_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_write_q <= 1'b0;
                    if (!uart_tx_full && (!pq_empty || lb_valid_q)) begin
                        grant_q    <= grant_d;
                        tx_data_q  <= tx_byte_d;
                        tx_write_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tx_write_q <= 1'b0;
                    rr_last_q  <= grant_q;
                    state_q    <= ST_GAP;
                end
                ST_GAP: begin
                    tx_write_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    tx_write_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_arbiter.sv
// Testbench for uart_io_arbiter: table-driven read-decode vectors plus
// directed multi-cycle sequences for queueing, overflow, loopback and reset.
module tb_uart_io_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] io_port_id;
    logic [7:0] io_write_data;
    logic       io_write_strobe;
    logic       io_read_strobe;
    logic [7:0] io_read_data;
    logic       debug_req;
    logic [7:0] uart_rx_data;
    logic       uart_rx_present;
    logic       uart_rx_ack;
    logic [7:0] uart_tx_data;
    logic       uart_tx_write;
    logic       uart_tx_full;
    logic       overflow;

    always #5 clk = ~clk;

    uart_io_arbiter #(
        .PQ_DEPTH (4),
        .PQ_AW    (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .io_port_id      (io_port_id),
        .io_write_data   (io_write_data),
        .io_write_strobe (io_write_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_read_data    (io_read_data),
        .debug_req       (debug_req),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_present (uart_rx_present),
        .uart_rx_ack     (uart_rx_ack),
        .uart_tx_data    (uart_tx_data),
        .uart_tx_write   (uart_tx_write),
        .uart_tx_full    (uart_tx_full),
        .overflow        (overflow)
    );

    // UART RX FIFO model: direct drive in table phase, queue model afterwards
    logic       rx_model_en;
    logic       tb_rx_present;
    logic [7:0] tb_rx_data;
    logic [7:0] rx_mem [16];
    int         rx_total;
    int         rx_pops  = 0;
    int         rx_under = 0;
    int         ack_count = 0;
    int         cyc = 0;
    logic [3:0] rx_idx;

    assign rx_idx          = rx_pops[3:0];
    assign uart_rx_present = rx_model_en ? (rx_total > rx_pops) : tb_rx_present;
    assign uart_rx_data    = rx_model_en ? rx_mem[rx_idx] : tb_rx_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_rx_ack) begin
            ack_count <= ack_count + 1;
            if (rx_model_en) begin
                if (rx_total > rx_pops) rx_pops <= rx_pops + 1;
                else rx_under <= rx_under + 1;
            end
        end
    end

    // TX push log
    logic [7:0] tx_log_data [$];
    int         tx_log_cyc [$];

    always @(negedge clk) begin
        if (uart_tx_write) begin
            tx_log_data.push_back(uart_tx_data);
            tx_log_cyc.push_back(cyc);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_b [8];

    typedef struct {
        logic [7:0] port;
        logic       present;
        logic [7:0] rxd;
        logic       full;
        logic [7:0] exp_rd;
        logic       exp_ack;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        io_port_id      = 8'h01;
        io_write_data   = d;
        io_write_strobe = 1'b1;
        step();
        io_write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p);
        io_port_id     = p;
        io_read_strobe = 1'b1;
        step();
        io_read_strobe = 1'b0;
    endtask

    task automatic wait_tx_write(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx_write) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_log(input string nm, input int base, input int n);
        check({nm, " count"}, tx_log_data.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < tx_log_data.size()) begin
                check($sformatf("%s byte%0d", nm, i), tx_log_data[base + i], exp_b[i]);
                if (i > 0)
                    check($sformatf("%s gap%0d", nm, i),
                          tx_log_cyc[base + i] - tx_log_cyc[base + i - 1], 3);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   base;
        int   ack_base;
        int   pop_base;
        logic ok;

        //             port   pres  rxd    full  exp_rd  ack
        vecs[0] = '{8'h01, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1};
        vecs[1] = '{8'h01, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{8'h02, 1'b1, 8'h11, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{8'h02, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h03, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h03, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h04, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{8'h05, 1'b1, 8'h33, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'h00, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0};
        vecs[9] = '{8'hFF, 1'b1, 8'h55, 1'b1, 8'h00, 1'b0};

        reset_n         = 1'b0;
        io_port_id      = 8'h00;
        io_write_data   = 8'h00;
        io_write_strobe = 1'b0;
        io_read_strobe  = 1'b0;
        debug_req       = 1'b0;
        uart_tx_full    = 1'b0;
        rx_model_en     = 1'b0;
        tb_rx_present   = 1'b0;
        tb_rx_data      = 8'h00;
        rx_total        = 0;
        for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;

        step();
        step();
        check("reset rd_data", io_read_data, 8'h00);
        check("reset rx_ack", uart_rx_ack, 1'b0);
        check("reset tx_write", uart_tx_write, 1'b0);
        check("reset tx_data", uart_tx_data, 8'h00);
        check("reset overflow", overflow, 1'b0);
        reset_n = 1'b1;
        step();

        // Read decode table
        for (int v = 0; v < 10; v++) begin
            io_port_id     = vecs[v].port;
            tb_rx_present  = vecs[v].present;
            tb_rx_data     = vecs[v].rxd;
            uart_tx_full   = vecs[v].full;
            io_read_strobe = 1'b1;
            step();
            check($sformatf("vec%0d rd_data", v), io_read_data, vecs[v].exp_rd);
            check($sformatf("vec%0d rx_ack", v), uart_rx_ack, vecs[v].exp_ack);
            io_read_strobe = 1'b0;
            io_port_id     = 8'h02;
            tb_rx_data     = ~vecs[v].rxd;
            step();
            check($sformatf("vec%0d hold", v), io_read_data, vecs[v].exp_rd);
            check($sformatf("vec%0d ack end", v), uart_rx_ack, 1'b0);
        end
        tb_rx_present = 1'b0;
        uart_tx_full  = 1'b0;
        step();

        // T2: two writes drain 3 cycles apart
        base = tx_log_data.size();
        wr(8'h41);
        wr(8'h42);
        for (int i = 0; i < 12; i++) step();
        exp_b[0] = 8'h41;
        exp_b[1] = 8'h42;
        check_log("t2", base, 2);

        // T3: fill queue with TX blocked, 5th byte dropped
        uart_tx_full = 1'b1;
        wr(8'hA0);
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        check("t3 no ovf at full", overflow, 1'b0);
        wr(8'hA4);
        check("t3 overflow set", overflow, 1'b1);
        rd(8'h04);
        check("t3 stat1", io_read_data, 8'h84);
        check("t3 overflow cleared", overflow, 1'b0);
        rd(8'h04);
        check("t3 stat2", io_read_data, 8'h04);
        uart_tx_full = 1'b0;
        rd(8'h03);
        check("t3 txf queue full", io_read_data, 8'h01);
        // Release, then push into the full queue in the cycle its head pops
        base = tx_log_data.size();
        wait_tx_write(ok);
        check("t3 issue seen", ok, 1'b1);
        wr(8'hA5);
        check("t3 push+pop no ovf", overflow, 1'b0);
        for (int i = 0; i < 20; i++) step();
        exp_b[0] = 8'hA0;
        exp_b[1] = 8'hA1;
        exp_b[2] = 8'hA2;
        exp_b[3] = 8'hA3;
        exp_b[4] = 8'hA5;
        check_log("t3", base, 5);
        rd(8'h04);
        check("t3 stat drained", io_read_data, 8'h00);

        // T6: queue 2 bytes + loopback byte, rr_last=processor -> loopback first
        rx_model_en  = 1'b1;
        rx_total     = rx_pops;
        step();
        uart_tx_full = 1'b1;
        wr(8'hC1);
        wr(8'hC2);
        ack_base  = ack_count;
        pop_base  = rx_pops;
        rx_mem[rx_idx] = 8'hD1;
        rx_total  = rx_pops + 1;
        debug_req = 1'b1;
        for (int i = 0; i < 8; i++) step();
        rd(8'h04);
        check("t6 stat lb_valid", io_read_data, 8'h22);
        check("t6 acks", ack_count - ack_base, 1);
        check("t6 pops", rx_pops - pop_base, 1);
        debug_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        base = tx_log_data.size();
        uart_tx_full = 1'b0;
        for (int i = 0; i < 16; i++) step();
        exp_b[0] = 8'hD1;
        exp_b[1] = 8'hC1;
        exp_b[2] = 8'hC2;
        check_log("t6", base, 3);

        // T5: loopback edge coincides with processor RX read
        ack_base = ack_count;
        pop_base = rx_pops;
        rx_mem[rx_idx]        = 8'hB1;
        rx_mem[rx_idx + 4'd1] = 8'hB2;
        rx_total  = rx_pops + 2;
        base      = tx_log_data.size();
        debug_req = 1'b1;
        step();
        step();
        rd(8'h01);
        check("t5 proc byte", io_read_data, 8'hB1);
        check("t5 proc ack", uart_rx_ack, 1'b1);
        for (int i = 0; i < 15; i++) step();
        check("t5 acks", ack_count - ack_base, 2);
        check("t5 pops", rx_pops - pop_base, 2);
        check("t5 rx underflow", rx_under, 0);
        exp_b[0] = 8'hB2;
        check_log("t5", base, 1);
        rd(8'h04);
        check("t5 stat idle", io_read_data, 8'h00);
        debug_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // T1: async reset in the middle of an ISSUE cycle
        uart_tx_full = 1'b1;
        wr(8'hE0);
        wr(8'hE1);
        wr(8'hE2);
        wr(8'hE3);
        wr(8'hE4);
        rd(8'h03);
        check("t1 pre rd_data", io_read_data, 8'h01);
        uart_tx_full = 1'b0;
        wait_tx_write(ok);
        check("t1 issue seen", ok, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t1 tx_write", uart_tx_write, 1'b0);
        check("t1 tx_data", uart_tx_data, 8'h00);
        check("t1 rd_data", io_read_data, 8'h00);
        check("t1 overflow", overflow, 1'b0);
        check("t1 rx_ack", uart_rx_ack, 1'b0);
        base = tx_log_data.size();
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("t1 no tx after reset", tx_log_data.size() - base, 0);
        rd(8'h04);
        check("t1 stat empty", io_read_data, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
